data_memory_hs: RTL and testbench

- Next-generation MIPS data memory: byte-addressed, word-organised synchronous RAM behind a valid/ready request/response handshake.
- Adds per-byte write strobes, configurable read latency, response backpressure and an out-of-range error flag.
- Sits between the MEM pipeline stage / load-store unit and on-chip data storage.
- Exactly one outstanding request at a time; every request, read or write, returns exactly one response.

---
 rtl/data_memory_pkg.sv | 24 ++
 rtl/data_memory_bank.sv | 37 +++
 rtl/data_memory_hs.sv | 186 ++++++++++++++++++
 tb/tb_data_memory_hs.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types and constants for the data_memory_hs block.
//   dmem_state_t   : handshake FSM states (IDLE, WAIT, RESP)
//   RD_LAT_MIN/MAX : legal range of the RD_LATENCY parameter
//   CNT_W          : width of the read-latency wait counter
//   byte_off_w()   : number of byte-offset address bits for a word width
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Counter is loaded with RD_LATENCY-2 at most, so this is ample.
  localparam int CNT_W = $clog2(RD_LAT_MAX);

  function automatic int byte_off_w(input int data_width);
    return (data_width <= 8) ? 0 : $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/data_memory_bank.sv
// data_memory_bank: lane-organised synchronous-write RAM with per-lane write
// strobes and a combinational read port. Each lane is its own array so a
// strobe touches only that lane's storage.
// Ports:
//   clk_in  : clock (writes on posedge)
//   we      : write enable (qualified per lane by be)
//   be      : per-lane write strobes
//   waddr   : write word index
//   wdata   : write data, one LANE_W field per lane
//   raddr   : read word index
//   rdata   : combinational read data
module data_memory_bank #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8,
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                              clk_in,
  input  logic                              we,
  input  logic [NUM_LANES-1:0]              be,
  input  logic [AW-1:0]                     waddr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
  input  logic [AW-1:0]                     raddr,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
      if (we && be[l]) mem[waddr] <= wdata[l];
    end

    assign rdata[l] = mem[raddr];
  end

endmodule

// File: rtl/data_memory_hs.sv
// data_memory_hs: byte-addressed, word-organised data RAM behind a
// valid/ready request/response handshake. One request outstanding at a time;
// every request (read or write) returns exactly one response.
//
// Ports:
//   clk_in, rst_in       : clock, synchronous active-high reset
//   req_valid_in/ready   : request handshake
//   req_wr_in            : 1 = write, 0 = read
//   req_addr_in          : byte address (low byte-offset bits ignored)
//   req_wdata_in/be_in   : write data and per-byte write strobes
//   resp_valid/ready     : response handshake
//   resp_rdata_out       : read data (0 for writes and range errors)
//   resp_err_out         : out-of-range (or stored-parity mismatch)
//   parity_inject_in     : only with DATA_MEMORY_PARITY_EN; flips stored
//                          parity of the lanes written by this request
//
// Build option: define DATA_MEMORY_PARITY_EN to store one even-parity bit per
// byte lane and flag mismatches on reads.
module data_memory_hs
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic                    req_wr_in,
  input  logic [ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [DATA_WIDTH-1:0]   req_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] req_be_in,
`ifdef DATA_MEMORY_PARITY_EN
  input  logic                    parity_inject_in,
`endif
  output logic                    resp_valid_out,
  input  logic                    resp_ready_in,
  output logic [DATA_WIDTH-1:0]   resp_rdata_out,
  output logic                    resp_err_out
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int BYTE_OFF  = byte_off_w(DATA_WIDTH);
  localparam int IDX_W     = $clog2(MEM_SIZE);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE) * 64'(NUM_LANES);
`ifdef DATA_MEMORY_PARITY_EN
  localparam int LANE_W = 9;  // {parity, byte}
`else
  localparam int LANE_W = 8;
`endif

  // Elaboration-time parameter checks
  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_lat
    $error("data_memory_hs: RD_LATENCY out of range 1..4");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_dw
    $error("data_memory_hs: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (MEM_SIZE < 2 || (1 << IDX_W) != MEM_SIZE) begin : g_bad_size
    $error("data_memory_hs: MEM_SIZE must be a power of 2 >= 2");
  end

  dmem_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;      // word index of the read in flight
  logic                  oor_q;      // that read was out of range
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept, oor, we;
  logic [IDX_W-1:0]      req_idx, raddr;
  logic [NUM_LANES-1:0][LANE_W-1:0] wr_lanes, rd_lanes;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_LANES-1:0]  lane_perr;
  logic                  rd_perr;

  assign req_ready_out = (state_q == IDLE);
  assign accept        = req_valid_in && req_ready_out;
  assign req_idx       = req_addr_in[BYTE_OFF +: IDX_W];
  assign oor           = (64'(req_addr_in) >= MEM_BYTES);

  // Reset wins over a write presented on the same edge.
  assign we    = accept && req_wr_in && !oor && !rst_in;
  // While idle the read port follows the request so a latency-1 read can
  // capture at the accept edge; afterwards it follows the latched index.
  assign raddr = (state_q == IDLE) ? req_idx : idx_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign rd_word[l*8 +: 8] = rd_lanes[l][7:0];
`ifdef DATA_MEMORY_PARITY_EN
    // Even parity: the stored 9-bit lane XORs to 0 when intact.
    assign wr_lanes[l]  = {(^req_wdata_in[l*8 +: 8]) ^ parity_inject_in,
                           req_wdata_in[l*8 +: 8]};
    assign lane_perr[l] = ^rd_lanes[l];
`else
    assign wr_lanes[l]  = req_wdata_in[l*8 +: 8];
    assign lane_perr[l] = 1'b0;
`endif
  end

  assign rd_perr = |lane_perr;

  data_memory_bank #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W),
    .DEPTH     (MEM_SIZE),
    .AW        (IDX_W)
  ) u_bank (
    .clk_in (clk_in),
    .we     (we),
    .be     (req_be_in),
    .waddr  (req_idx),
    .wdata  (wr_lanes),
    .raddr  (raddr),
    .rdata  (rd_lanes)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          if (req_wr_in) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = oor;
          end else if (RD_LATENCY == 1) begin
            state_d = RESP;
            rdata_d = oor ? '0 : rd_word;
            err_d   = oor | rd_perr;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = oor_q ? '0 : rd_word;
          err_d   = oor_q | rd_perr;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_in) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        idx_q <= req_idx;
        oor_q <= oor;
      end
    end
  end

  assign resp_valid_out = (state_q == RESP);
  assign resp_rdata_out = rdata_q;
  assign resp_err_out   = err_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: four instances with RD_LATENCY 1..4 share the
// request fields; only the selected one sees req_valid.
module tb_data_memory_hs;

  localparam int NDUT = 4;

  logic        clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic            rst_in;
  logic [NDUT-1:0] req_valid;
  logic            req_wr;
  logic [31:0]     req_addr, req_wdata;
  logic [3:0]      req_be;
  logic            resp_ready;
  logic [NDUT-1:0] req_ready, resp_valid, resp_err;
  logic [31:0]     resp_rdata [NDUT];
`ifdef DATA_MEMORY_PARITY_EN
  logic            parity_inject;
`endif

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    data_memory_hs #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(256), .RD_LATENCY(i + 1)
    ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .req_valid_in    (req_valid[i]),
      .req_ready_out   (req_ready[i]),
      .req_wr_in       (req_wr),
      .req_addr_in     (req_addr),
      .req_wdata_in    (req_wdata),
      .req_be_in       (req_be),
`ifdef DATA_MEMORY_PARITY_EN
      .parity_inject_in(parity_inject),
`endif
      .resp_valid_out  (resp_valid[i]),
      .resp_ready_in   (resp_ready),
      .resp_rdata_out  (resp_rdata[i]),
      .resp_err_out    (resp_err[i])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [17];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One complete transaction on instance sel. bp = cycles of response
  // backpressure; hold_next keeps a read request asserted through the
  // response so its acceptance timing can be checked.
  task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int bp, input logic hold_next);
    exp_t        e;
    int          n;
    logic [31:0] held;
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = '0; req_valid[sel] = 1'b1;
    n = 0;
    while (!req_ready[sel] && n < 20) begin tick(); n++; end
    if (!req_ready[sel]) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: dut %0d never ready", sel);
      req_valid = '0;
      return;
    end
    e.rdata = exp_rd; e.err = exp_err; e.lat = wr ? 1 : sel + 1;
    sb.push_back(e);
    tick();  // accept edge
    req_valid = '0;
`ifdef DATA_MEMORY_PARITY_EN
    parity_inject = 1'b0;
`endif
    n = 1;
    while (!resp_valid[sel] && n < 20) begin
      chk("ready_low_wait", {31'b0, req_ready[sel]}, 32'd0);
      tick(); n++;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    held = resp_rdata[sel];
    if (hold_next) begin req_wr = 1'b0; req_valid[sel] = 1'b1; end
    for (int k = 0; k < bp; k++) begin
      chk("bp_valid", {31'b0, resp_valid[sel]}, 32'd1);
      chk("bp_rdata_stable", resp_rdata[sel], held);
      chk("bp_ready_low", {31'b0, req_ready[sel]}, 32'd0);
      tick();
    end
    chk("rdata", resp_rdata[sel], e.rdata);
    chk("err", {31'b0, resp_err[sel]}, {31'b0, e.err});
    resp_ready = 1'b1;
    tick();  // handshake edge
    resp_ready = 1'b0;
    chk("valid_after_hs", {31'b0, resp_valid[sel]}, 32'd0);
    chk("ready_after_hs", {31'b0, req_ready[sel]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h0000_0012, 32'h00AA_0000, 4'h4, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAA_BEEF, 1'b0},
      '{1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1},
      '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1122_3344, 1'b0},
      '{1'b1, 32'h0000_0013, 32'h5500_0000, 4'h8, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0011, 32'h0000_0000, 4'h0, 32'h55AA_BEEF, 1'b0},
      '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0},
      '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_0016, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0},
      '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0},
      '{1'b0, 32'h0000_03FF, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 1'b0},
      '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h0000_0500, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1}
    };

    rst_in = 1'b1; req_valid = '0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
`ifdef DATA_MEMORY_PARITY_EN
    parity_inject = 1'b0;
`endif
    tick(); tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_ready", {31'b0, req_ready[i]}, 32'd1);
      chk("rst_valid", {31'b0, resp_valid[i]}, 32'd0);
      chk("rst_rdata", resp_rdata[i], 32'd0);
      chk("rst_err", {31'b0, resp_err[i]}, 32'd0);
    end
    rst_in = 1'b0;
    tick();

    // Latency 1: table of writes/reads, merges, range edges
    for (int v = 0; v < 17; v++)
      do_req(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be,
             vecs[v].exp_rdata, vecs[v].exp_err, 0, 1'b0);

    // Write presented on a reset edge must not land
    req_wr = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    req_valid = '0; req_valid[0] = 1'b1; rst_in = 1'b1;
    tick();
    rst_in = 1'b0; req_valid = '0;
    chk("rstwr_valid", {31'b0, resp_valid[0]}, 32'd0);
    chk("rstwr_ready", {31'b0, req_ready[0]}, 32'd1);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1122_3344, 1'b0, 0, 1'b0);

    // Latency 2: WAIT path including an out-of-range read
    do_req(1, 1'b1, 32'h40, 32'h8765_4321, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h8765_4321, 1'b0, 2, 1'b0);
    do_req(1, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);

    // Latency 3: 5-cycle backpressure with the next read held pending
    do_req(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    do_req(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b1);
    do_req(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

    // Latency 4: reset while waiting abandons the read
    do_req(3, 1'b1, 32'h10, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    do_req(3, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0102_0304, 1'b0, 0, 1'b0);
    req_wr = 1'b0; req_addr = 32'h10; req_valid = '0; req_valid[3] = 1'b1;
    tick();
    req_valid = '0;
    chk("wait_ready_low", {31'b0, req_ready[3]}, 32'd0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_ready", {31'b0, req_ready[3]}, 32'd1);
    chk("midrst_valid", {31'b0, resp_valid[3]}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("midrst_no_resp", {31'b0, resp_valid[3]}, 32'd0);
      tick();
    end
    do_req(3, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0102_0304, 1'b0, 0, 1'b0);

`ifdef DATA_MEMORY_PARITY_EN
    parity_inject = 1'b1;
    do_req(0, 1'b1, 32'h20, 32'h0F0F_0F0F, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b1, 0, 1'b0);
    do_req(0, 1'b1, 32'h24, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    do_req(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
